// File: rtl/sequenciador_chave_pkg.sv
// Shared AES-128 key-schedule constants: word/key widths, S-box, Rcon and the
// sequencer state encoding.
package sequenciador_chave_pkg;

    localparam int AES_WORD_W = 32;
    localparam int AES_KEY_W  = 128;
    localparam int RODADA_W   = 4;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EXPANDE = 2'd1,
        FIM     = 2'd2
    } estado_t;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants indexed by round number; unused slots are zero.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/sequenciador_chave_funcao_g.sv
// Key-schedule g function: RotWord, SubWord and the round-constant XOR.
module funcao_g
    import sequenciador_chave_pkg::*;
(
    input  logic [AES_WORD_W-1:0] palavra,
    input  logic [RODADA_W-1:0]   rodada,
    output logic [AES_WORD_W-1:0] t
);

    logic [AES_WORD_W-1:0] rot_s;
    logic [AES_WORD_W-1:0] sub_s;

    // Rotate left by one byte, then substitute each byte through the S-box
    always_comb begin
        rot_s = {palavra[23:0], palavra[31:24]};
        sub_s = {sbox_lookup(rot_s[31:24]), sbox_lookup(rot_s[23:16]),
                 sbox_lookup(rot_s[15:8]),  sbox_lookup(rot_s[7:0])};
    end

    assign t = sub_s ^ {RCON[rodada], 24'h000000};

endmodule

// File: rtl/sequenciador_chave.sv
// AES-128 round-key sequencer: emits round keys 0..N_RODADAS one per accepted
// handshake, with stall, abort and a completion pulse.
module sequenciador_chave
    import sequenciador_chave_pkg::*;
#(
    parameter int N_RODADAS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inicio,
    input  logic [AES_KEY_W-1:0] chave,
    input  logic                 cancelar,
    input  logic                 pronto,
    output logic                 valido,
    output logic [AES_KEY_W-1:0] chave_rodada,
    output logic [RODADA_W-1:0]  rodada,
    output logic                 ocupado,
    output logic                 concluido
);

    localparam logic [RODADA_W-1:0] ULTIMA = RODADA_W'(N_RODADAS);

    estado_t               estado_r;
    logic [AES_KEY_W-1:0]  chave_r;
    logic [RODADA_W-1:0]   rodada_r;
    logic                  valido_r;
    logic                  ocupado_r;
    logic                  concluido_r;

    logic [AES_WORD_W-1:0] t_s;
    logic [RODADA_W-1:0]   prox_rodada_s;
    logic [AES_WORD_W-1:0] n0_s, n1_s, n2_s, n3_s;
    logic [AES_KEY_W-1:0]  prox_chave_s;

    assign prox_rodada_s = rodada_r + 4'd1;

    funcao_g u_funcao_g (
        .palavra (chave_r[31:0]),
        .rodada  (prox_rodada_s),
        .t       (t_s)
    );

    // Next round key: XOR chain across the four words of the current key
    always_comb begin
        n0_s         = chave_r[127:96] ^ t_s;
        n1_s         = chave_r[95:64]  ^ n0_s;
        n2_s         = chave_r[63:32]  ^ n1_s;
        n3_s         = chave_r[31:0]   ^ n2_s;
        prox_chave_s = {n0_s, n1_s, n2_s, n3_s};
    end

    // Sequencing FSM: start capture, round stepping, completion pulse and abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r    <= OCIOSO;
            chave_r     <= 128'd0;
            rodada_r    <= 4'd0;
            valido_r    <= 1'b0;
            ocupado_r   <= 1'b0;
            concluido_r <= 1'b0;
        end else begin
            case (estado_r)
                OCIOSO: begin
                    concluido_r <= 1'b0;
                    if (inicio && !cancelar) begin
                        estado_r  <= EXPANDE;
                        chave_r   <= chave;
                        rodada_r  <= 4'd0;
                        valido_r  <= 1'b1;
                        ocupado_r <= 1'b1;
                    end else begin
                        valido_r  <= 1'b0;
                        ocupado_r <= 1'b0;
                    end
                end
                EXPANDE: begin
                    if (cancelar) begin
                        estado_r    <= OCIOSO;
                        valido_r    <= 1'b0;
                        ocupado_r   <= 1'b0;
                        concluido_r <= 1'b0;
                    end else if (valido_r && pronto) begin
                        if (rodada_r < ULTIMA) begin
                            chave_r  <= prox_chave_s;
                            rodada_r <= prox_rodada_s;
                        end else begin
                            estado_r    <= FIM;
                            valido_r    <= 1'b0;
                            concluido_r <= 1'b1;
                        end
                    end else begin
                        concluido_r <= 1'b0;
                    end
                end
                FIM: begin
                    // Completion pulse lasts only this state; cancel lands in the same place
                    estado_r    <= OCIOSO;
                    valido_r    <= 1'b0;
                    ocupado_r   <= 1'b0;
                    concluido_r <= 1'b0;
                end
                default: begin
                    estado_r    <= OCIOSO;
                    valido_r    <= 1'b0;
                    ocupado_r   <= 1'b0;
                    concluido_r <= 1'b0;
                end
            endcase
        end
    end

    assign valido       = valido_r;
    assign chave_rodada = chave_r;
    assign rodada       = rodada_r;
    assign ocupado      = ocupado_r;
    assign concluido    = concluido_r;

endmodule

// File: tb/tb_sequenciador_chave.sv
// Directed bench for sequenciador_chave using the FIPS-197 key expansion vector.
module tb_sequenciador_chave;

    localparam logic [127:0] CHAVE_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk;
    logic         rst_n;
    logic         inicio;
    logic [127:0] chave;
    logic         cancelar;
    logic         pronto;
    logic         valido;
    logic [127:0] chave_rodada;
    logic [3:0]   rodada;
    logic         ocupado;
    logic         concluido;

    int n_comp  = 0;
    int n_falha = 0;

    logic [127:0] esp_k [0:10];

    sequenciador_chave #(.N_RODADAS(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inicio       (inicio),
        .chave        (chave),
        .cancelar     (cancelar),
        .pronto       (pronto),
        .valido       (valido),
        .chave_rodada (chave_rodada),
        .rodada       (rodada),
        .ocupado      (ocupado),
        .concluido    (concluido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [127:0] obtido, input logic [127:0] esperado);
        n_comp++;
        if (obtido !== esperado) begin
            n_falha++;
            $display("FAIL %s: obtido=%h esperado=%h", tag, obtido, esperado);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic confere_chave(input int r);
        verifica($sformatf("valido_r%0d", r), 128'(valido), 128'd1);
        verifica($sformatf("rodada_r%0d", r), 128'(rodada), 128'(r));
        verifica($sformatf("chave_r%0d", r), chave_rodada, esp_k[r]);
    endtask

    task automatic confere_flags(input string tag, input logic v, input logic o, input logic c);
        verifica({tag, "_valido"}, 128'(valido), 128'(v));
        verifica({tag, "_ocupado"}, 128'(ocupado), 128'(o));
        verifica({tag, "_concluido"}, 128'(concluido), 128'(c));
    endtask

    task automatic inicia(input logic [127:0] k);
        chave  = k;
        inicio = 1'b1;
        ciclo();
        inicio = 1'b0;
        confere_chave(0);
        verifica("ocupado_inicio", 128'(ocupado), 128'd1);
    endtask

    task automatic avanca(input int de, input int ate);
        for (int r = de + 1; r <= ate; r++) begin
            ciclo();
            confere_chave(r);
        end
    endtask

    task automatic termina(input string tag);
        ciclo();
        confere_flags({tag, "_fim"}, 1'b0, 1'b1, 1'b1);
        ciclo();
        confere_flags({tag, "_ocioso"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        esp_k[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        esp_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        esp_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        esp_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        esp_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        esp_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        esp_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        esp_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        esp_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        esp_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
        esp_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n    = 1'b0;
        inicio   = 1'b0;
        cancelar = 1'b0;
        pronto   = 1'b0;
        chave    = 128'd0;

        // Reset state
        #2;
        confere_flags("reset", 1'b0, 1'b0, 1'b0);
        verifica("reset_rodada", 128'(rodada), 128'd0);
        verifica("reset_chave", chave_rodada, 128'd0);
        #10 rst_n = 1'b1;
        ciclo();

        // Continuous pronto: one key per cycle, then completion pulse
        pronto = 1'b1;
        inicia(CHAVE_A);
        avanca(0, 10);
        termina("continuo");

        // Stall at round 3, then resume
        inicia(CHAVE_A);
        avanca(0, 3);
        pronto = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ciclo();
            confere_chave(3);
        end
        pronto = 1'b1;
        avanca(3, 10);
        termina("parada");

        // inicio with a different key during expansion is ignored
        inicia(CHAVE_A);
        avanca(0, 2);
        chave  = 128'h00112233445566778899aabbccddeeff;
        inicio = 1'b1;
        ciclo();
        inicio = 1'b0;
        confere_chave(3);
        avanca(3, 10);
        termina("ignora");

        // Cancel at round 5, immediate restart
        inicia(CHAVE_A);
        avanca(0, 5);
        cancelar = 1'b1;
        ciclo();
        cancelar = 1'b0;
        confere_flags("cancela", 1'b0, 1'b0, 1'b0);
        inicia(CHAVE_A);
        avanca(0, 7);

        // Asynchronous reset between edges at round 7
        #2 rst_n = 1'b0;
        #1;
        confere_flags("rst_meio", 1'b0, 1'b0, 1'b0);
        verifica("rst_meio_rodada", 128'(rodada), 128'd0);
        verifica("rst_meio_chave", chave_rodada, 128'd0);
        #2 rst_n = 1'b1;
        ciclo();
        confere_flags("pos_rst", 1'b0, 1'b0, 1'b0);
        inicia(CHAVE_A);
        avanca(0, 1);

        // Return to idle, then inicio together with cancelar must not start
        cancelar = 1'b1;
        ciclo();
        confere_flags("cancela2", 1'b0, 1'b0, 1'b0);
        inicio = 1'b1;
        ciclo();
        inicio   = 1'b0;
        cancelar = 1'b0;
        confere_flags("simult", 1'b0, 1'b0, 1'b0);
        ciclo();
        confere_flags("simult_seg", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falha);
        $finish;
    end

endmodule

// File: doc/sequenciador_chave.md
SEQUENCIADOR_CHAVE -- requirements
Module: sequenciador_chave

Interface
REQ-001 Parameter N_RODADAS, default 10, is the last round index emitted; the legal range is 1..10, bounded by the Rcon table length.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-004 inicio  input  1  is a start request, sampled only in state OCIOSO.
REQ-005 chave  input  128  is the AES-128 cipher key, captured when a start is accepted; w0 = chave[127:96] … w3 = chave[31:0].
REQ-006 cancelar  input  1  is a synchronous abort of the current expansion.
REQ-007 pronto  input  1  is consumer ready for the current round key.
REQ-008 valido  output  1  means chave_rodada and rodada hold a valid round key.
REQ-009 chave_rodada  output  128  is the current round key {w4r, w4r+1, w4r+2, w4r+3}.
REQ-010 rodada  output  4  is the index of the round key being presented (0..N_RODADAS).
REQ-011 ocupado  output  1  is high in every state other than OCIOSO.
REQ-012 concluido  output  1  is a one-cycle pulse after the last round key is accepted.

Function
REQ-013 The FSM SHALL have states OCIOSO, EXPANDE and FIM.
REQ-014 In OCIOSO with inicio=1 and cancelar=0: chave is registered, and on the next edge the FSM enters EXPANDE with valido=1, rodada=0 and chave_rodada=chave.
REQ-015 In EXPANDE, a transfer occurs on any edge where valido=1 and pronto=1.
REQ-016 On a transfer with rodada<N_RODADAS: the next round key is loaded and rodada increments by 1; valido stays 1, so one key per cycle under continuous pronto.
REQ-017 Next key: t = SubWord(RotWord(w3)) XOR {Rcon[rodada+1], 24'h0}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-018 Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36; all XORs are 32-bit with no carries.
REQ-019 With valido=1 and pronto=0, chave_rodada, rodada and valido SHALL hold stable, with no limit on the stall length.
REQ-020 On a transfer with rodada=N_RODADAS: valido drops to 0 and the FSM enters FIM.
REQ-021 FIM SHALL assert concluido for exactly one cycle, then return to OCIOSO.
REQ-022 inicio outside OCIOSO SHALL be ignored; it is not queued.
REQ-023 cancelar=1 in EXPANDE or FIM: the next state is OCIOSO, valido=0 and concluido=0 on the next cycle, and the pending transfer is discarded.
REQ-024 cancelar=1 in OCIOSO has no effect.
REQ-025 If cancelar and inicio are asserted in the same cycle, cancelar wins and inicio is dropped.
REQ-026 After a cancel or after completion, a new inicio SHALL be accepted in the first OCIOSO cycle.
REQ-027 Key update is combinational from the current key register plus a single register stage; there are no multicycle paths.

Reset
REQ-028 rst_n=0 SHALL immediately force state=OCIOSO, valido=0, concluido=0, ocupado=0, rodada=0 and chave_rodada=0.
REQ-029 Reset asserted mid-expansion SHALL abandon the sequence; no concluido is produced.
REQ-030 Outputs SHALL be registered and change only on clk edges after reset deassertion.

Structure
REQ-031 A shared package SHALL hold the S-box table, the Rcon table, the FSM state typedef and the AES word/key width constants.
REQ-032 Sub-module funcao_g (inputs: 32-bit word and 4-bit round; output: 32-bit t) SHALL implement RotWord, SubWord and the Rcon XOR; it is instantiated once.

Verification
REQ-033 Key 2b7e151628aed2a6abf7158809cf4f3c with pronto=1 held -> rodada 0..10 on 11 consecutive cycles, showing:
- rodada 1: a0fafe1788542cb123a339392a6c7605
- rodada 10: d014f9a8c9ee2589e13f0cc8b6630ca6
- concluido pulses on the cycle after rodada 10 is accepted.
REQ-034 Same key, pronto=0 for 5 cycles at rodada 3 -> key and rodada are unchanged throughout the stall; the sequence resumes with rodada 4 = ef44a541a8525b7fb671253bdb0bad00.
REQ-035 inicio pulsed during EXPANDE with a different key -> it is ignored and the sequence completes with the original keys.
REQ-036 cancelar at rodada 5 -> valido=0 and ocupado=0 next cycle with no concluido; an immediate new inicio restarts from rodada 0.
REQ-037 rst_n pulled low between edges at rodada 7 -> all outputs are 0 immediately, and a new inicio after release restarts cleanly.
REQ-038 inicio and cancelar asserted together in OCIOSO -> no start; valido stays 0.
